conv_req_sched: RTL and testbench
=================================

# conv_req_sched

Request scheduler that sits directly upstream of the code-converter top level. It buffers incoming conversion requests of 4-bit value plus 2-bit mode in a small FIFO and drives the converter's start/in/sel inputs one request at a time. It waits for the matching done flag, captures the selected result, and presents it on a valid/ready result port. Bad modes and converter hangs are reported as error responses rather than stalling the pipeline.

## Interface
Parameters:
- DEPTH, 4: request FIFO depth; power of two, ≥ 2.
- TIMEOUT, 15: maximum cycles spent in WAIT before an error response; 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept; equals !full.
- req_in  in  4  value to convert.
- req_sel  in  2  mode: 00 Gray, 01 BCD, 10 Excess-3, 11 invalid.
- cv_start  out  1  one-cycle start pulse to the converter.
- cv_in  out  4  value to the converter, held from ISSUE through WAIT.
- cv_sel  out  2  mode to the converter, held from ISSUE through WAIT.
- cv_done_gray, cv_done_bcd, cv_done_excess3  in  1 each  converter completion flags.
- cv_gray  in  4  Gray result.
- cv_bcd  in  8  BCD result.
- cv_ex3  in  8  Excess-3 result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  8  result; Gray is zero-extended; 0 on error.
- res_sel  out  2  mode of this result.
- res_err  out  1  invalid mode or timeout.
- count  out  log2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE.

## Operation
- FIFO:
  - A push occurs on req_valid && req_ready.
  - When full, req_ready = 0. There is no bypass, so a push cannot occur in the same cycle a full FIFO pops.
  - Simultaneous push and pop when not full leaves count unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, pop its head into cur_in/cur_sel.
  - If the popped sel is 11, go to RESP with err = 1 and data = 0, without starting the converter.
  - Otherwise go to ISSUE.
- ISSUE:
  - cv_start = 1 for exactly this cycle; clear the WAIT counter.
  - Next state is WAIT.
- WAIT:
  - The done flag matching cur_sel (00 gray, 01 bcd, 10 excess3) captures the matching result into res_data with err = 0, then goes to RESP.
  - Non-matching done flags are ignored.
  - If the counter reaches TIMEOUT with no matching done, go to RESP with err = 1 and data = 0.
- RESP:
  - res_valid = 1; res_data, res_sel and res_err are stable until the handshake.
  - On res_ready, go to IDLE.
- cv_in/cv_sel:
  - Driven from cur_* in ISSUE and WAIT.
  - Retain their last value in other states.
- Reset (rst = 0, any time, including mid-WAIT):
  - FIFO emptied, count = 0, state = IDLE.
  - cv_start, cv_in, cv_sel, res_valid, res_data, res_sel, res_err and busy all go to 0 immediately.
  - req_ready = 1, but pushes are ignored while reset is asserted.
  - No in-flight response survives reset.

## Timing
- Push at edge E0 → IDLE pops at E1 → cv_start high between E1 and E2.
- WAIT is entered at E2; a matching done sampled at edge Ek moves the FSM to RESP, and res_valid is high from Ek.
- Latency from push edge to res_valid = 2 + converter cycles (from WAIT entry to done) + 1.
- Invalid sel: res_valid is asserted one cycle after the pop.
- Timeout: res_valid asserted TIMEOUT+3 cycles after the push into an empty, idle block.
- Back-to-back throughput: one request per (4 + converter latency) cycles, with res_ready held high.
- A done flag asserted during ISSUE is not sampled.
- busy = 1 in ISSUE, WAIT and RESP.

## Test plan
- Gray mode:
  - Stimulus: reset, then push in = 4'b0110, sel = 00; model drives cv_done_gray with cv_gray = 4'b0101 three cycles after cv_start.
  - Required: exactly one cv_start pulse with cv_in = 0110; res_data = 8'h05, res_err = 0, res_sel = 00.
- Fill to capacity:
  - Stimulus: with the FSM stalled by res_ready = 0, push DEPTH+1 requests.
  - Required: count reaches 4 and req_ready drops; the 5th request is not accepted until a pop.
  - Release res_ready: results come out in FIFO order (BCD 9 → 8'h09, Excess-3 9 → 8'h0C).
- Invalid mode:
  - Stimulus: push sel = 11, in = 4'h3.
  - Required: no cv_start; res_valid one cycle after the pop with res_err = 1, res_data = 0.
- Timeout:
  - Stimulus: push sel = 01; never assert cv_done_bcd; pulse cv_done_gray during WAIT.
  - Required: gray done ignored; res_err = 1 after TIMEOUT WAIT cycles.
- Result back-pressure:
  - Stimulus: hold res_ready = 0 for 10 cycles in RESP.
  - Required: res_data/res_sel/res_err stable; no further cv_start until the handshake.
- Reset mid-operation:
  - Stimulus: assert rst = 0 during WAIT with 2 entries queued.
  - Required: all outputs return to reset values asynchronously and count = 0.
  - After release, no stale response appears.

Source files
------------

// File: rtl/conv_req_sched_if.sv
// Request / converter / result bundle around conv_req_sched.
// slave is the scheduler's view, master is the driver/consumer view.
interface conv_req_sched_if #(
  parameter int CW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_in;
  logic [1:0]    req_sel;
  logic          cv_start;
  logic [3:0]    cv_in;
  logic [1:0]    cv_sel;
  logic          cv_done_gray;
  logic          cv_done_bcd;
  logic          cv_done_excess3;
  logic [3:0]    cv_gray;
  logic [7:0]    cv_bcd;
  logic [7:0]    cv_ex3;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic [1:0]    res_sel;
  logic          res_err;
  logic [CW-1:0] count;
  logic          busy;

  modport slave (
    input  req_valid, req_in, req_sel,
    input  cv_done_gray, cv_done_bcd, cv_done_excess3, cv_gray, cv_bcd, cv_ex3,
    input  res_ready,
    output req_ready, cv_start, cv_in, cv_sel,
    output res_valid, res_data, res_sel, res_err, count, busy
  );

  modport master (
    output req_valid, req_in, req_sel,
    output cv_done_gray, cv_done_bcd, cv_done_excess3, cv_gray, cv_bcd, cv_ex3,
    output res_ready,
    input  req_ready, cv_start, cv_in, cv_sel,
    input  res_valid, res_data, res_sel, res_err, count, busy
  );
endinterface

// File: rtl/conv_req_sched.sv
// Request scheduler in front of the code converter: FIFO of {value, mode},
// one conversion in flight at a time, result/error on a valid/ready port.
module conv_req_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  conv_req_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0] in;
    logic [1:0] sel;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] SEL_BAD = 2'b11;

  state_t        state, state_nx;
  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          full, empty, push, pop;
  logic [1:0]    cur_sel;
  logic [7:0]    wcnt;
  logic          match, expired;
  logic [7:0]    sel_data;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign push  = bus.req_valid && !full;
  assign head  = mem[rptr];

  assign bus.req_ready = !full;
  assign bus.count     = cnt;

  // Done flag and result belonging to the mode currently in flight.
  always_comb begin
    match    = 1'b0;
    sel_data = '0;
    unique case (cur_sel)
      2'b00:   begin match = bus.cv_done_gray;    sel_data = {4'b0, bus.cv_gray}; end
      2'b01:   begin match = bus.cv_done_bcd;     sel_data = bus.cv_bcd;          end
      2'b10:   begin match = bus.cv_done_excess3; sel_data = bus.cv_ex3;          end
      default: begin match = 1'b0;                sel_data = '0;                  end
    endcase
  end

  assign expired = (wcnt == 8'(TIMEOUT));

  // FIFO storage; writes while reset is held are dropped.
  always_ff @(posedge clk) begin
    if (push && rst) mem[wptr] <= '{in: bus.req_in, sel: bus.req_sel};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // FSM next state.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!empty) state_nx = (head.sel == SEL_BAD) ? RESP : ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (match || expired) state_nx = RESP;
      RESP:  if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    pop           = 1'b0;
    bus.cv_start  = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      IDLE:    begin pop = !empty; bus.busy = 1'b0; end
      ISSUE:   bus.cv_start  = 1'b1;
      RESP:    bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: converter operands latch only for valid modes so cv_in/cv_sel
  // keep their last issued value across bad-mode responses; the response
  // registers load once on RESP entry and hold through back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_sel      <= '0;
      bus.cv_in    <= '0;
      bus.cv_sel   <= '0;
      wcnt         <= '0;
      bus.res_data <= '0;
      bus.res_sel  <= '0;
      bus.res_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (pop) begin
          cur_sel <= head.sel;
          if (head.sel == SEL_BAD) begin
            bus.res_data <= '0;
            bus.res_sel  <= head.sel;
            bus.res_err  <= 1'b1;
          end else begin
            bus.cv_in  <= head.in;
            bus.cv_sel <= head.sel;
          end
        end
        ISSUE: wcnt <= '0;
        WAIT: begin
          if (match) begin
            bus.res_data <= sel_data;
            bus.res_sel  <= cur_sel;
            bus.res_err  <= 1'b0;
          end else if (expired) begin
            bus.res_data <= '0;
            bus.res_sel  <= cur_sel;
            bus.res_err  <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_req_sched.sv
// Directed bench for conv_req_sched: table of single requests plus
// hand-written fill/back-pressure and mid-WAIT reset sequences.
module tb_conv_req_sched;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_req_sched_if #(.CW(CW)) bus ();

  conv_req_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Converter model knobs: cycles after the start pulse to raise the
  // matching done (-1 = never, 0 = during ISSUE), and a stray gray done.
  int       m_delay = 1;
  bit       m_wrong = 1'b0;
  int       nstart;
  logic [3:0] seen_in;

  typedef struct {
    logic [3:0] in;
    logic [1:0] sel;
    int         dly;
    bit         wrong;
    logic [7:0] exp_data;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Converter model: real Gray/BCD/Excess-3 of whatever cv_in was issued.
  initial begin
    int lim;
    logic [1:0] s;
    logic [3:0] v;
    nstart = 0;
    seen_in = '0;
    bus.cv_done_gray = 1'b0;
    bus.cv_done_bcd = 1'b0;
    bus.cv_done_excess3 = 1'b0;
    bus.cv_gray = '0;
    bus.cv_bcd = '0;
    bus.cv_ex3 = '0;
    forever begin
      @(negedge clk);
      if (bus.cv_start) begin
        nstart++;
        v = bus.cv_in;
        s = bus.cv_sel;
        seen_in = v;
        bus.cv_gray = v ^ (v >> 1);
        bus.cv_bcd  = (v >= 4'd10) ? {4'd1, v - 4'd10} : {4'd0, v};
        bus.cv_ex3  = {4'd0, v} + 8'd3;
        lim = (m_delay > 1) ? m_delay : 1;
        for (int i = 0; i <= lim; i++) begin
          bus.cv_done_gray    = (m_delay == i && s == 2'b00) || (m_wrong && i == 1);
          bus.cv_done_bcd     = (m_delay == i && s == 2'b01);
          bus.cv_done_excess3 = (m_delay == i && s == 2'b10);
          @(negedge clk);
        end
        bus.cv_done_gray = 1'b0;
        bus.cv_done_bcd = 1'b0;
        bus.cv_done_excess3 = 1'b0;
      end
    end
  end

  // Offer one request from a negedge; returns at the negedge after the push.
  task automatic push(input logic [3:0] i, input logic [1:0] s);
    bus.req_valid = 1'b1;
    bus.req_in = i;
    bus.req_sel = s;
    for (int k = 0; k < 50 && !bus.req_ready; k++) @(negedge clk);
    if (!bus.req_ready) chk("push_ready_timeout", 0, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid; lat counts negedges from the call.
  task automatic get_resp(output bit got, output logic [7:0] d, output logic [1:0] s,
                          output logic e, output int lat);
    got = 1'b0; d = '0; s = '0; e = 1'b0; lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.res_valid) begin
        got = 1'b1; d = bus.res_data; s = bus.res_sel; e = bus.res_err;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (got) @(negedge clk);
  endtask

  initial begin
    bit         got;
    logic [7:0] d;
    logic [1:0] s;
    logic       e;
    int         lat, s0, bad;
    logic [7:0] fexp [5];
    logic [1:0] fsel [5];

    vecs[0] = '{4'h6, 2'b00, 3,  1'b0, 8'h05, 1'b0, 5};
    vecs[1] = '{4'h9, 2'b01, 1,  1'b0, 8'h09, 1'b0, 3};
    vecs[2] = '{4'h9, 2'b10, 2,  1'b0, 8'h0C, 1'b0, 4};
    vecs[3] = '{4'hD, 2'b01, 2,  1'b0, 8'h13, 1'b0, 4};
    vecs[4] = '{4'hF, 2'b00, 1,  1'b0, 8'h08, 1'b0, 3};
    vecs[5] = '{4'h3, 2'b11, 1,  1'b0, 8'h00, 1'b1, 1};
    vecs[6] = '{4'h5, 2'b01, -1, 1'b1, 8'h00, 1'b1, 18};
    vecs[7] = '{4'hF, 2'b10, 0,  1'b0, 8'h00, 1'b1, 18};
    vecs[8] = '{4'h0, 2'b10, 4,  1'b0, 8'h03, 1'b0, 6};

    bus.req_valid = 1'b0;
    bus.req_in = '0;
    bus.req_sel = '0;
    bus.res_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_cv_start", bus.cv_start, 0);
    chk("rst_res_data", bus.res_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single requests, one at a time.
    for (int r = 0; r < NV; r++) begin
      m_delay = vecs[r].dly;
      m_wrong = vecs[r].wrong;
      s0 = nstart;
      push(vecs[r].in, vecs[r].sel);
      get_resp(got, d, s, e, lat);
      chk($sformatf("v%0d_seen", r), got, 1);
      chk($sformatf("v%0d_data", r), d, vecs[r].exp_data);
      chk($sformatf("v%0d_sel", r), s, vecs[r].sel);
      chk($sformatf("v%0d_err", r), e, vecs[r].exp_err);
      chk($sformatf("v%0d_lat", r), lat, vecs[r].exp_lat);
      chk($sformatf("v%0d_starts", r), nstart - s0, (vecs[r].sel == 2'b11) ? 0 : 1);
      if (vecs[r].sel != 2'b11) chk($sformatf("v%0d_cv_in", r), seen_in, vecs[r].in);
    end
    m_wrong = 1'b0;
    m_delay = 1;

    // Fill to capacity behind a stalled response, then drain in order.
    bus.res_ready = 1'b0;
    push(4'h9, 2'b01);
    for (int k = 0; k < 20 && !bus.res_valid; k++) @(negedge clk);
    chk("fill_a_valid", bus.res_valid, 1);
    push(4'h9, 2'b10);
    push(4'h6, 2'b00);
    push(4'hC, 2'b01);
    push(4'h0, 2'b10);
    chk("fill_count", bus.count, 4);
    chk("fill_ready", bus.req_ready, 0);
    s0 = nstart;
    bus.req_valid = 1'b1;
    bus.req_in = 4'hF;
    bus.req_sel = 2'b00;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.count != 3'(4) || bus.req_ready || !bus.res_valid ||
          bus.res_data != 8'h09 || bus.res_sel != 2'b01 || bus.res_err) bad++;
    end
    chk("stall_stable", bad, 0);
    chk("stall_no_start", nstart - s0, 0);
    bus.res_ready = 1'b1;
    get_resp(got, d, s, e, lat);
    chk("fill_a_data", d, 8'h09);
    chk("fill_a_lat", lat, 0);
    for (int k = 0; k < 10 && !bus.req_ready; k++) @(negedge clk);
    chk("fill_after_pop_count", bus.count, 3);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("fill_fifth_in", bus.count, 4);
    fexp = '{8'h0C, 8'h05, 8'h12, 8'h03, 8'h08};
    fsel = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    for (int k = 0; k < 5; k++) begin
      get_resp(got, d, s, e, lat);
      chk($sformatf("drain%0d_seen", k), got, 1);
      chk($sformatf("drain%0d_data", k), d, fexp[k]);
      chk($sformatf("drain%0d_sel", k), s, fsel[k]);
      chk($sformatf("drain%0d_err", k), e, 0);
    end
    chk("drain_count", bus.count, 0);

    // Reset in WAIT with two requests queued.
    m_delay = -1;
    push(4'h5, 2'b00);
    repeat (3) @(negedge clk);
    push(4'h1, 2'b01);
    push(4'h2, 2'b10);
    chk("pre_rst_count", bus.count, 2);
    chk("pre_rst_busy", bus.busy, 1);
    s0 = nstart;
    rst = 1'b0;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cv", {bus.cv_start, bus.cv_in, bus.cv_sel}, 0);
    chk("mid_rst_res", {bus.res_valid, bus.res_data, bus.res_sel, bus.res_err}, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_in = 4'h7;
    bus.req_sel = 2'b00;
    @(negedge clk);
    chk("rst_push_ignored", bus.count, 0);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) bad++;
    end
    chk("post_rst_stale", bad, 0);
    chk("post_rst_starts", nstart - s0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
